// File: rtl/shake_pkg.sv
// Shared constants and state type for the SHAKE256 squeeze-side output reader.
package shake_pkg;

  localparam int RATE_BITS     = 1088;
  localparam int WORD_W        = 64;
  localparam int WORDS_PER_BLK = 17;
  localparam int CNT_W         = 12;
  localparam int IDX_W         = 5;
  localparam int MSB_W         = 11;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BLK,
    STREAM,
    FINISH
  } state_t;

  // Word 0 sits in the most significant 64 bits of the rate block.
  function automatic logic [MSB_W-1:0] word_msb(input logic [IDX_W-1:0] idx);
    return MSB_W'(RATE_BITS - 1 - WORD_W * int'(idx));
  endfunction

endpackage

// File: rtl/shake_squeeze_reader.sv
// Streams 64-bit words out of successive SHAKE256 rate blocks, requesting a fresh
// permutation every 17 words. Define SHAKE_SQZ_ERR_EN to add a sticky protocol-error output.
module shake_squeeze_reader
  import shake_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CNT_W-1:0]     out_words,
  input  logic [RATE_BITS-1:0] hash_in,
  input  logic                 squeezed,
  output logic                 squeeze_req,
  output logic [WORD_W-1:0]    dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 dout_last,
  output logic                 busy,
  output logic                 done
`ifdef SHAKE_SQZ_ERR_EN
  ,
  output logic                 err
`endif
);

  state_t               state_q, state_d;
  logic [RATE_BITS-1:0] blk_q;
  logic [CNT_W-1:0]     remaining_q;
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     idx_sel;
  logic                 squeeze_req_q;
  logic                 done_q;

  logic start_ok;
  logic blk_take;
  logic xfer;
  logic last_xfer;
  logic wrap_xfer;

  assign start_ok  = (state_q == IDLE) && start;
  assign blk_take  = (state_q == WAIT_BLK) && squeezed;
  assign xfer      = (state_q == STREAM) && dout_ready;
  assign last_xfer = xfer && (remaining_q == CNT_W'(1));
  assign wrap_xfer = xfer && (remaining_q != CNT_W'(1))
                     && (idx_q == IDX_W'(WORDS_PER_BLK - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (start && (out_words != '0)) state_d = WAIT_BLK;
      WAIT_BLK: if (squeezed) state_d = STREAM;
      STREAM: begin
        if (last_xfer)      state_d = FINISH;
        else if (wrap_xfer) state_d = WAIT_BLK;
      end
      FINISH:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // NOTE: the rate buffer is cleared on reset so no stale hash output can
  // leak onto dout after a reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      blk_q         <= '0;
      remaining_q   <= '0;
      idx_q         <= '0;
      squeeze_req_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      if (start_ok) remaining_q <= out_words;
      if (blk_take) begin
        blk_q <= hash_in;
        idx_q <= '0;
      end
      if (xfer) begin
        remaining_q <= remaining_q - CNT_W'(1);
        idx_q       <= idx_q + IDX_W'(1);
      end
      squeeze_req_q <= wrap_xfer;
      done_q        <= (start_ok && (out_words == '0)) || last_xfer;
    end
  end

  // idx_q reaches 17 only while waiting for the next block; keep the select in range.
  assign idx_sel = (idx_q > IDX_W'(WORDS_PER_BLK - 1)) ? '0 : idx_q;

  always_comb begin
    dout_valid = (state_q == STREAM);
    dout       = dout_valid ? blk_q[word_msb(idx_sel) -: WORD_W] : '0;
    dout_last  = dout_valid && (remaining_q == CNT_W'(1));
    busy       = (state_q != IDLE);
  end

  assign squeeze_req = squeeze_req_q;
  assign done        = done_q;

`ifdef SHAKE_SQZ_ERR_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      err <= 1'b0;
    end else if ((squeezed && (state_q != WAIT_BLK)) || (start && (state_q != IDLE))) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_shake_squeeze_reader.sv
// Randomized bench for shake_squeeze_reader: a sponge stand-in feeds random blocks
// and a word-stream model predicts every dout, dout_last, and squeeze count.
module tb_shake_squeeze_reader;
  import shake_pkg::*;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 start;
  logic [CNT_W-1:0]     out_words;
  logic [RATE_BITS-1:0] hash_in;
  logic                 squeezed;
  logic                 squeeze_req;
  logic [WORD_W-1:0]    dout;
  logic                 dout_valid;
  logic                 dout_ready;
  logic                 dout_last;
  logic                 busy;
  logic                 done;
`ifdef SHAKE_SQZ_ERR_EN
  logic                 err;
  logic                 err_exp;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clock = ~clock;

  shake_squeeze_reader dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .out_words   (out_words),
    .hash_in     (hash_in),
    .squeezed    (squeezed),
    .squeeze_req (squeeze_req),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .dout_last   (dout_last),
    .busy        (busy),
    .done        (done)
`ifdef SHAKE_SQZ_ERR_EN
    ,
    .err         (err)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [RATE_BITS-1:0] rand_block();
    logic [RATE_BITS-1:0] r;
    for (int i = 0; i < RATE_BITS / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_squeeze_req"}, squeeze_req, 0);
    check({tag, "_dout"},        dout,        0);
    check({tag, "_dout_valid"},  dout_valid,  0);
    check({tag, "_dout_last"},   dout_last,   0);
    check({tag, "_busy"},        busy,        0);
    check({tag, "_done"},        done,        0);
`ifdef SHAKE_SQZ_ERR_EN
    check({tag, "_err"},         err,         0);
`endif
  endtask

  // mode: 0 = always ready, 1 = toggling ready, 2 = random ready.
  task automatic run(input int n, input int mode, input bit fixed_top,
                     input bit strays, input int abort_at);
    logic [RATE_BITS-1:0] blocks[$];
    logic [RATE_BITS-1:0] b;
    logic [63:0]          held = '0;
    logic [63:0]          exp_w;
    int  k = 0, sqz = 0, delay, cyc = 0, first_cyc = -1, last_cyc = -1;
    bit  pending = 1'b1, gave_blk = 1'b0, stall = 1'b0, forced = 1'b0;
    bit  fin = 1'b0, aborted = 1'b0;

    @(negedge clock);
    start     = 1'b1;
    out_words = CNT_W'(n);
    squeezed  = 1'b0;
    @(negedge clock);
    start = 1'b0;
    delay = $urandom_range(0, 2);

    while (!fin && !aborted && cyc < 3000) begin
      case (mode)
        0:       dout_ready = 1'b1;
        1:       dout_ready = ~dout_ready;
        default: dout_ready = 1'($urandom_range(0, 1));
      endcase

      if (gave_blk) check("valid_after_squeezed", dout_valid, 1);
      if (stall) begin
        check("stall_dout", dout, held);
        check("stall_valid", dout_valid, 1);
      end
      if (squeeze_req) begin
        sqz++;
        check("valid_low_in_wait", dout_valid, 0);
        pending = 1'b1;
        delay   = $urandom_range(0, 3);
      end

      if (abort_at >= 0 && k >= abort_at) begin
        reset    = 1'b0;
        squeezed = 1'b0;
        start    = 1'b0;
        @(negedge clock);
        check_all_zero("abort");
        reset   = 1'b1;
`ifdef SHAKE_SQZ_ERR_EN
        err_exp = 1'b0;
`endif
        aborted = 1'b1;
      end else if (done) begin
        fin = 1'b1;
        check("done_after_last", 64'(cyc - last_cyc), 1);
      end else begin
        if (dout_valid && dout_ready) begin
          b     = (k / WORDS_PER_BLK < blocks.size()) ? blocks[k / WORDS_PER_BLK] : '0;
          exp_w = 64'(b >> (RATE_BITS - WORD_W * (k % WORDS_PER_BLK + 1)));
          check("dout", dout, exp_w);
          check("dout_last", dout_last, 64'(k == n - 1));
          if (fixed_top && k == 0) check("first_word", dout, 64'hA5A5_0000_0000_0001);
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
          k++;
        end
        stall = dout_valid && !dout_ready;
        held  = dout;

        squeezed = 1'b0;
        start    = 1'b0;
        gave_blk = 1'b0;
        if (pending) begin
          if (delay == 0) begin
            b = rand_block();
            if (fixed_top && blocks.size() == 0) b[RATE_BITS-1 -: WORD_W] = 64'hA5A5_0000_0000_0001;
            hash_in = b;
            blocks.push_back(b);
            squeezed = 1'b1;
            pending  = 1'b0;
            gave_blk = 1'b1;
          end else begin
            delay--;
          end
        end else if (strays && dout_valid && (!forced || $urandom_range(0, 7) == 0)) begin
          // Unsolicited squeeze/start: the reader must carry on as if nothing happened.
          forced   = 1'b1;
          hash_in  = rand_block();
          squeezed = 1'b1;
          if ($urandom_range(0, 1) == 1) begin
            start     = 1'b1;
            out_words = CNT_W'($urandom_range(0, 50));
          end
`ifdef SHAKE_SQZ_ERR_EN
          err_exp = 1'b1;
`endif
        end
        @(negedge clock);
        cyc++;
      end
    end

    squeezed = 1'b0;
    start    = 1'b0;
    if (aborted) return;
    if (!fin) begin
      check("timeout", 0, 1);
      return;
    end
    check("word_count", 64'(k), 64'(n));
    check("squeeze_count", 64'(sqz), 64'((n + WORDS_PER_BLK - 1) / WORDS_PER_BLK - 1));
    if (mode == 0 && n <= WORDS_PER_BLK) check("back_to_back", 64'(last_cyc - first_cyc), 64'(n - 1));
`ifdef SHAKE_SQZ_ERR_EN
    check("err", err, err_exp);
`endif
    @(negedge clock);
    check("idle_busy", busy, 0);
    check("done_width", done, 0);
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    squeezed   = 1'b0;
    hash_in    = '0;
    out_words  = '0;
    dout_ready = 1'b0;
`ifdef SHAKE_SQZ_ERR_EN
    err_exp    = 1'b0;
`endif
    repeat (2) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b1;

    run(5, 0, 1'b1, 1'b0, -1);
    run(40, 0, 1'b0, 1'b0, -1);
    run(17, 1, 1'b0, 1'b0, -1);

    @(negedge clock);
    start     = 1'b1;
    out_words = '0;
    @(negedge clock);
    start = 1'b0;
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_valid", dout_valid, 0);
    @(negedge clock);
    check("zero_done_end", done, 0);
    check("zero_busy_end", busy, 0);
    check("zero_valid_end", dout_valid, 0);

    run(20, 0, 1'b0, 1'b0, 9);
    run(3, 0, 1'b0, 1'b0, -1);
    run(20, 0, 1'b0, 1'b1, -1);

    for (int i = 0; i < 6; i++) begin
      run($urandom_range(1, 60), $urandom_range(0, 2), 1'b0, 1'b1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/shake_squeeze_reader.md
SHAKE_SQUEEZE_READER -- requirements
Module: shake_squeeze_reader

Interface
REQ-001 SHALL have port clock, input, 1, sole clock, all logic on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-003 SHALL have port start, input, 1, single-cycle request to begin an output run.
REQ-004 SHALL have port out_words, input, 12, number of 64-bit output words requested; sampled on accepted start.
REQ-005 SHALL have port hash_in, input, 1088, rate block from the sponge (hash output of SHAKE256).
REQ-006 SHALL have port squeezed, input, 1, one-cycle pulse marking hash_in valid.
REQ-007 SHALL have port squeeze_req, output, 1, one-cycle pulse requesting one further permutation.
REQ-008 SHALL have port dout, output, 64, output word.
REQ-009 SHALL have port dout_valid, output, 1, dout holds a valid word.
REQ-010 SHALL have port dout_ready, input, 1, downstream accepts dout.
REQ-011 SHALL have port dout_last, output, 1, high with the final word of a run.
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-013 SHALL have port done, output, 1, one-cycle pulse at run completion.

Function
REQ-014 SHALL implement states IDLE, WAIT_BLK, STREAM, FINISH.
REQ-015 IDLE: start with out_words>0 SHALL latch out_words into remaining counter and enter WAIT_BLK; start with out_words=0 SHALL pulse done next cycle and remain IDLE.
REQ-016 WAIT_BLK: squeezed SHALL capture hash_in into a 1088-bit buffer, clear word index to 0, enter STREAM; dout_valid SHALL rise the cycle after squeezed.
REQ-017 STREAM: dout SHALL equal buffer word at index i, word i = buffer[1087-64*i -: 64] (word 0 = MSBs), 17 words per block.
REQ-018 A transfer SHALL occur only when dout_valid and dout_ready are both high; each transfer decrements remaining and increments index.
REQ-019 dout and dout_valid SHALL hold stable while dout_valid is high and dout_ready is low.
REQ-020 dout_last SHALL be high exactly when dout_valid is high and remaining=1.
REQ-021 Transfer with remaining=1 SHALL enter FINISH; FINISH SHALL pulse done for one cycle then return to IDLE.
REQ-022 Transfer of word 16 with remaining>1 SHALL pulse squeeze_req in the following cycle and enter WAIT_BLK; dout_valid SHALL be low in WAIT_BLK.
REQ-023 Block arithmetic: a run of N words SHALL issue exactly ceil(N/17)-1 squeeze_req pulses.
REQ-024 squeezed outside WAIT_BLK SHALL be ignored (buffer unchanged).
REQ-025 start outside IDLE SHALL be ignored.
REQ-026 Simultaneous squeezed and start in IDLE: start SHALL be taken, squeezed ignored.

Reset
REQ-027 reset low at a rising edge SHALL force IDLE, clear buffer, counter, index; squeeze_req, dout, dout_valid, dout_last, busy, done SHALL be 0 the following cycle, including mid-run.

Configuration
REQ-028 With macro SHAKE_SQZ_ERR_EN defined, an extra output err (1 bit, reset 0) SHALL be provided and set sticky on squeezed outside WAIT_BLK or start while busy, cleared only by reset.
REQ-029 Without SHAKE_SQZ_ERR_EN, port err SHALL not exist and those events SHALL be silently ignored.

Structure
REQ-030 Package shake_pkg SHALL hold RATE_BITS=1088, WORD_W=64, WORDS_PER_BLK=17, and the state enum typedef.
REQ-031 The block SHALL be a single module with no sub-module; the word select SHALL be an indexed part-select on the buffer.

Verification
REQ-032 start, out_words=5, squeezed with hash_in[1087:1024]=64'hA5A5_0000_0000_0001, ready=1 -> 5 words on consecutive cycles, first word 64'hA5A5_0000_0000_0001, dout_last on word 5, done one cycle later, no squeeze_req.
REQ-033 out_words=40, ready=1 -> exactly 2 squeeze_req pulses (after words 17 and 34), 40 transfers, dout_last on word 40.
REQ-034 out_words=17 with dout_ready toggling 1/0 every cycle -> dout stable during stalls, 17 transfers, zero squeeze_req.
REQ-035 out_words=0 -> done pulse next cycle, busy stays 0, dout_valid never asserted.
REQ-036 reset low at word 9 of a 20-word run -> all outputs 0 next cycle, state IDLE; new start with out_words=3 completes normally.
REQ-037 With SHAKE_SQZ_ERR_EN: squeezed pulse during STREAM -> err=1, buffer and dout unchanged, run completes.
